fluxo_dados_param: RTL and testbench

Parametrised datapath for the memory-sequence game: address and limit (round) counters, a synchronous N-bit-wide game RAM with write mode, a registered play, a play/memory comparator, a play-edge detector and a sticky timeout counter. Sits under the game control unit, which drives all zera*/conta*/registra*/escreve* strobes and reads the status flags; debug outputs go to the board displays.

---
 rtl/fluxo_dados_param.sv | 170 +++++++++++++++++
 tb/tb_fluxo_dados_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_param.sv
// fluxo_dados_param
// Datapath for the memory-sequence game. It holds the address counter E, the
// limit (round) counter L, the play register, the game RAM with its read
// register, the play-edge detector and a sticky timeout counter. The control
// unit drives every strobe and reads the status flags. Debug outputs go to
// the board displays.
//
// Ports
//   clock, reset         : system clock; asynchronous active-high reset
//   zeraE / contaE       : clear / increment address counter E
//   zeraL / contaL       : clear / increment limit counter L
//   zeraR / registraR    : clear / load the play register from chaves
//   escreveM             : write the play register into RAM[E]
//   zeraT / contaT       : clear / advance the timeout counter
//   chaves [N]           : raw play keys
//   jogada_igual         : RAM read register == play register
//   enderecoIgualLimite  : E == L
//   enderecoMenorLimite  : E < L (unsigned)
//   fimE / fimL          : E / L at terminal count 2^M-1
//   jogada_feita         : one-cycle pulse when the keys first go nonzero
//   timeout              : sticky timeout flag
//   db_tem_jogada        : OR of the keys (combinational)
//   db_contagem/db_limite: E / L
//   db_memoria/db_jogada : RAM read register / play register
//
// Handshake: there is no valid/ready traffic here. Every strobe is a
// single-cycle level that the datapath samples on the rising clock edge, and
// every flag is a plain combinational function of the registered state.
module fluxo_dados_param #(
  parameter int N       = 4,
  parameter int M       = 4,
  parameter int TIMEOUT = 5000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zeraE,
  input  logic         contaE,
  input  logic         zeraL,
  input  logic         contaL,
  input  logic         zeraR,
  input  logic         registraR,
  input  logic         escreveM,
  input  logic         zeraT,
  input  logic         contaT,
  input  logic [N-1:0] chaves,
  output logic         jogada_igual,
  output logic         enderecoIgualLimite,
  output logic         enderecoMenorLimite,
  output logic         fimE,
  output logic         fimL,
  output logic         jogada_feita,
  output logic         timeout,
  output logic         db_tem_jogada,
  output logic [M-1:0] db_contagem,
  output logic [M-1:0] db_limite,
  output logic [N-1:0] db_memoria,
  output logic [N-1:0] db_jogada
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam int DEPTH = 1 << M;

  logic [M-1:0]  e_cnt;
  logic [M-1:0]  l_cnt;
  logic [N-1:0]  play_reg;
  logic [N-1:0]  rd_reg;
  logic          tem_hist;
  logic [TW-1:0] t_cnt;
  logic          t_flag;
  logic          tem_jogada;

  // Game memory. It is deliberately outside the reset domain so a reset
  // keeps the stored sequence.
  logic [N-1:0]  mem [DEPTH];

  // Address counter E: clear beats increment; wraps modulo 2^M.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_cnt <= '0;
    end else if (zeraE) begin
      e_cnt <= '0;
    end else if (contaE) begin
      e_cnt <= e_cnt + 1'b1;
    end
  end

  // Limit counter L: same priority and modulus as E.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      l_cnt <= '0;
    end else if (zeraL) begin
      l_cnt <= '0;
    end else if (contaL) begin
      l_cnt <= l_cnt + 1'b1;
    end
  end

  // Play register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      play_reg <= '0;
    end else if (zeraR) begin
      play_reg <= '0;
    end else if (registraR) begin
      play_reg <= chaves;
    end
  end

  // RAM write uses the E and play register values from before the edge, so
  // contaE together with escreveM writes the old address.
  always_ff @(posedge clock) begin
    if (escreveM) begin
      mem[e_cnt] <= play_reg;
    end
  end

  // Read register loads every edge; on a write edge it picks up the old word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_reg <= '0;
    end else begin
      rd_reg <= mem[e_cnt];
    end
  end

  // Edge-detector history of "any key pressed".
  assign tem_jogada = |chaves;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tem_hist <= 1'b0;
    end else begin
      tem_hist <= tem_jogada;
    end
  end

  // Timeout: the counter walks 0..TIMEOUT-1 under contaT; the next contaT
  // edge at TIMEOUT-1 raises the flag, after which the counter freezes and
  // the flag sticks until zeraT or reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t_cnt  <= '0;
      t_flag <= 1'b0;
    end else if (zeraT) begin
      t_cnt  <= '0;
      t_flag <= 1'b0;
    end else if (contaT && !t_flag) begin
      if (t_cnt == T_LAST) begin
        t_flag <= 1'b1;
      end else begin
        t_cnt <= t_cnt + 1'b1;
      end
    end
  end

  assign jogada_igual        = (rd_reg == play_reg);
  assign enderecoIgualLimite = (e_cnt == l_cnt);
  assign enderecoMenorLimite = (e_cnt < l_cnt);
  assign fimE                = (e_cnt == {M{1'b1}});
  assign fimL                = (l_cnt == {M{1'b1}});
  assign jogada_feita        = tem_jogada & ~tem_hist;
  assign timeout             = t_flag;
  assign db_tem_jogada       = tem_jogada;
  assign db_contagem         = e_cnt;
  assign db_limite           = l_cnt;
  assign db_memoria          = rd_reg;
  assign db_jogada           = play_reg;

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed bench for fluxo_dados_param with N=4, M=4, TIMEOUT=8.
// Inputs change 1 time unit after each rising edge; outputs are checked at
// that same point, i.e. well away from the next active edge.
module tb_fluxo_dados_param;

  localparam int N = 4;
  localparam int M = 4;
  localparam int TIMEOUT = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic         escreveM, zeraT, contaT;
  logic [N-1:0] chaves;
  logic         jogada_igual, enderecoIgualLimite, enderecoMenorLimite;
  logic         fimE, fimL, jogada_feita, timeout, db_tem_jogada;
  logic [M-1:0] db_contagem, db_limite;
  logic [N-1:0] db_memoria, db_jogada;

  int checks   = 0;
  int failures = 0;
  int pulses;
  int tem_cycles;

  fluxo_dados_param #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
    .clock              (clock),
    .reset              (reset),
    .zeraE              (zeraE),
    .contaE             (contaE),
    .zeraL              (zeraL),
    .contaL             (contaL),
    .zeraR              (zeraR),
    .registraR          (registraR),
    .escreveM           (escreveM),
    .zeraT              (zeraT),
    .contaT             (contaT),
    .chaves             (chaves),
    .jogada_igual       (jogada_igual),
    .enderecoIgualLimite(enderecoIgualLimite),
    .enderecoMenorLimite(enderecoMenorLimite),
    .fimE               (fimE),
    .fimL               (fimL),
    .jogada_feita       (jogada_feita),
    .timeout            (timeout),
    .db_tem_jogada      (db_tem_jogada),
    .db_contagem        (db_contagem),
    .db_limite          (db_limite),
    .db_memoria         (db_memoria),
    .db_jogada          (db_jogada)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic idle();
    zeraE = 0; contaE = 0; zeraL = 0; contaL = 0; zeraR = 0;
    registraR = 0; escreveM = 0; zeraT = 0; contaT = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_step();
    step();
    idle();
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_E"},      32'(db_contagem), 0);
    check({pfx, "_L"},      32'(db_limite), 0);
    check({pfx, "_mem"},    32'(db_memoria), 0);
    check({pfx, "_play"},   32'(db_jogada), 0);
    check({pfx, "_igual"},  32'(jogada_igual), 1);
    check({pfx, "_eqlim"},  32'(enderecoIgualLimite), 1);
    check({pfx, "_ltlim"},  32'(enderecoMenorLimite), 0);
    check({pfx, "_fimE"},   32'(fimE), 0);
    check({pfx, "_fimL"},   32'(fimL), 0);
    check({pfx, "_feita"},  32'(jogada_feita), 0);
    check({pfx, "_tout"},   32'(timeout), 0);
  endtask

  initial begin
    idle();
    chaves = '0;
    reset  = 1'b1;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;
    step();

    // Write 0010 at E=3, read it back, then mismatch with 0100.
    for (int i = 0; i < 3; i++) begin contaE = 1; pulse_step(); end
    check("e_at3", 32'(db_contagem), 3);
    chaves = 4'b0010; registraR = 1; pulse_step();
    check("play_0010", 32'(db_jogada), 4'b0010);
    escreveM = 1; pulse_step();
    step();
    check("mem_0010", 32'(db_memoria), 4'b0010);
    check("igual_hit", 32'(jogada_igual), 1);
    chaves = 4'b0100; registraR = 1; pulse_step();
    check("play_0100", 32'(db_jogada), 4'b0100);
    check("mem_keep", 32'(db_memoria), 4'b0010);
    check("igual_miss", 32'(jogada_igual), 0);
    zeraR = 1; pulse_step();
    check("play_zero", 32'(db_jogada), 0);

    // E wrap and fimE.
    zeraE = 1; pulse_step();
    for (int i = 1; i <= 15; i++) begin contaE = 1; pulse_step(); end
    check("e_15", 32'(db_contagem), 15);
    check("fimE_15", 32'(fimE), 1);
    contaE = 1; pulse_step();
    check("e_wrap", 32'(db_contagem), 0);
    check("fimE_wrap", 32'(fimE), 0);
    contaE = 1; pulse_step();
    zeraE = 1; contaE = 1; pulse_step();
    check("e_zera_wins", 32'(db_contagem), 0);

    // L=2, E stepping 0..3.
    zeraL = 1; pulse_step();
    contaL = 1; pulse_step();
    contaL = 1; pulse_step();
    check("l_2", 32'(db_limite), 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lt_e%0d", i), 32'(enderecoMenorLimite), (i < 2) ? 1 : 0);
      check($sformatf("eq_e%0d", i), 32'(enderecoIgualLimite), (i == 2) ? 1 : 0);
      contaE = 1; pulse_step();
    end
    for (int i = 2; i < 15; i++) begin contaL = 1; pulse_step(); end
    check("fimL_15", 32'(fimL), 1);
    zeraL = 1; contaL = 1; pulse_step();
    check("l_zera_wins", 32'(db_limite), 0);

    // Edge detector: keys 0 -> 1000 held five cycles.
    chaves = '0; step(); step();
    chaves = 4'b1000;
    pulses = 0; tem_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (jogada_feita) pulses++;
      if (db_tem_jogada) tem_cycles++;
      step();
    end
    check("feita_pulses", 32'(pulses), 1);
    check("tem_cycles", 32'(tem_cycles), 5);
    check("feita_held", 32'(jogada_feita), 0);
    chaves = '0; step();

    // Timeout after the 8th consecutive contaT edge.
    zeraT = 1; pulse_step();
    check("tout_clear0", 32'(timeout), 0);
    contaT = 1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      step();
      check($sformatf("tout_edge%0d", i), 32'(timeout), (i == TIMEOUT) ? 1 : 0);
    end
    contaT = 0; step(); step();
    check("tout_sticky", 32'(timeout), 1);
    zeraT = 1; pulse_step();
    check("tout_zeraT", 32'(timeout), 0);

    // Asynchronous reset mid-count: E=5, L=3, timeout=1.
    zeraE = 1; zeraL = 1; pulse_step();
    for (int i = 0; i < 5; i++) begin contaE = 1; contaL = (i < 3); pulse_step(); end
    contaT = 1;
    for (int i = 0; i < TIMEOUT; i++) step();
    contaT = 0;
    chaves = 4'b0001; registraR = 1; pulse_step();
    chaves = '0;
    check("pre_E", 32'(db_contagem), 5);
    check("pre_L", 32'(db_limite), 3);
    check("pre_tout", 32'(timeout), 1);
    check("pre_play", 32'(db_jogada), 1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("async");
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
